wal_mac_dot: RTL and testbench

Streaming unsigned 8-bit dot-product engine placed directly downstream of the 8x8 Wallace-tree multiplier. It accepts operand pairs over a valid/ready handshake, multiplies each pair through the Wallace multiplier, and accumulates up to N_TERMS products. It then emits the sum on a valid/ready result port. It turns the combinational multiplier into a pipelined multiply-accumulate stage for filter and correlation datapaths.

---
 rtl/wal_mac_pkg.sv | 24 ++
 rtl/walmult8x8.sv | 66 ++++++
 rtl/wal_mac_dot.sv | 162 ++++++++++++++++
 tb/tb_wal_mac_dot.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wal_mac_pkg.sv
`default_nettype none
//==============================================================================
// Module      : wal_mac_pkg
// Description : Shared constants and FSM state type for the wal_mac_dot
//               streaming dot-product engine and its Wallace multiplier.
//               MUL_W  - operand width of the multiplier
//               PROD_W - full product width
//               CNT_W  - width of the product/term counters
// Revision    : 1.0 - initial release
//==============================================================================
package wal_mac_pkg;

   localparam int MUL_W  = 8;
   localparam int PROD_W = 16;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : wal_mac_pkg
`default_nettype wire

// File: rtl/walmult8x8.sv
`default_nettype none
//==============================================================================
// Module      : walmult8x8
// Description : Combinational unsigned 8x8 Wallace-tree multiplier.
//               Eight shifted partial-product rows are compressed by layers of
//               3:2 carry-save adders (8 -> 6 -> 4 -> 3 -> 2 rows) and the two
//               surviving rows are summed by one carry-propagate adder.
// Ports       : opA     in  MUL_W   unsigned operand A
//               opB     in  MUL_W   unsigned operand B
//               product out PROD_W  opA * opB
// Revision    : 1.0 - initial release
//==============================================================================
module walmult8x8
   import wal_mac_pkg::*;
(
   input  logic [MUL_W-1:0]  opA,
   input  logic [MUL_W-1:0]  opB,
   output logic [PROD_W-1:0] product
);

   // Word-level 3:2 compressor; returns {carry, sum}. Carries out of the top
   // bit are dropped: the true product always fits in PROD_W bits, so the
   // modulo-2^PROD_W reduction is exact.
   function automatic logic [2*PROD_W-1:0] csa(
      input logic [PROD_W-1:0] x,
      input logic [PROD_W-1:0] y,
      input logic [PROD_W-1:0] z
   );
      logic [PROD_W-1:0] s;
      logic [PROD_W-1:0] c;
      s = x ^ y ^ z;
      c = ((x & y) | (x & z) | (y & z)) << 1;
      return {c, s};
   endfunction

   logic [PROD_W-1:0] w_pp [MUL_W];
   logic [PROD_W-1:0] w_l1 [6];
   logic [PROD_W-1:0] w_l2 [4];
   logic [PROD_W-1:0] w_l3 [3];
   logic [PROD_W-1:0] w_l4 [2];

   generate
      for (genvar i = 0; i < MUL_W; i++) begin : g_pp
         assign w_pp[i] = PROD_W'(opA & {MUL_W{opB[i]}}) << i;
      end
   endgenerate

   always_comb begin
      // layer 1: 8 rows -> 6
      {w_l1[1], w_l1[0]} = csa(w_pp[0], w_pp[1], w_pp[2]);
      {w_l1[3], w_l1[2]} = csa(w_pp[3], w_pp[4], w_pp[5]);
      w_l1[4]            = w_pp[6];
      w_l1[5]            = w_pp[7];
      // layer 2: 6 rows -> 4
      {w_l2[1], w_l2[0]} = csa(w_l1[0], w_l1[1], w_l1[2]);
      {w_l2[3], w_l2[2]} = csa(w_l1[3], w_l1[4], w_l1[5]);
      // layer 3: 4 rows -> 3
      {w_l3[1], w_l3[0]} = csa(w_l2[0], w_l2[1], w_l2[2]);
      w_l3[2]            = w_l2[3];
      // layer 4: 3 rows -> 2
      {w_l4[1], w_l4[0]} = csa(w_l3[0], w_l3[1], w_l3[2]);
      product            = w_l4[0] + w_l4[1];
   end

endmodule : walmult8x8
`default_nettype wire

// File: rtl/wal_mac_dot.sv
`default_nettype none
//==============================================================================
// Module      : wal_mac_dot
// Description : Streaming unsigned 8-bit dot-product engine. Operand pairs
//               arrive over valid/ready, are multiplied by walmult8x8, the
//               product is registered and then accumulated. A packet ends on
//               in_last or after N_TERMS beats; the sum is then presented on a
//               valid/ready result port.
//               Optional feature macro: MAC_SAT_EN - saturating accumulation
//               with a sticky overflow flag (default: wrap-around, out_ovf=0).
// Parameters  : N_TERMS - max products per packet (2..255)
//               ACC_W   - accumulator / result width (16..32)
// Ports       : clk       in   1      clock, rising edge
//               rst       in   1      synchronous reset, active low
//               in_valid  in   1      operand pair valid
//               in_ready  out  1      operand pair accepted
//               in_a/in_b in   8      unsigned operands
//               in_last   in   1      ends the packet on this beat
//               out_valid out  1      result valid
//               out_ready in   1      result accepted
//               out_sum   out  ACC_W  accumulated sum
//               out_count out  8      number of products in the sum
//               out_ovf   out  1      accumulator saturated
// Revision    : 1.0 - initial release
//==============================================================================
module wal_mac_dot
   import wal_mac_pkg::*;
#(
   parameter int N_TERMS = 8,
   parameter int ACC_W   = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [MUL_W-1:0] in_a,
   input  logic [MUL_W-1:0] in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   localparam logic [CNT_W-1:0] c_LAST_TERM = CNT_W'(N_TERMS - 1);

   state_t              r_state;
   logic                r_inReady;
   logic                r_outValid;
   logic [PROD_W-1:0]   w_prod;
   logic [PROD_W-1:0]   r_prodQ;
   logic                r_prodV;
   logic                r_prodLast;
   logic [ACC_W-1:0]    r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    r_termCnt;
   logic                w_accept;
   logic                w_terminal;
   logic [ACC_W-1:0]    w_base;
   logic [ACC_W-1:0]    w_addend;
   logic [ACC_W-1:0]    w_next;

   walmult8x8 u_mult (
      .opA     (in_a),
      .opB     (in_b),
      .product (w_prod)
   );

   // r_inReady is only ever set in ACC, so it alone qualifies acceptance.
   assign w_accept   = in_valid && r_inReady;
   // in_last on the N_TERMS-th beat is the same single terminal event.
   assign w_terminal = w_accept && (in_last || (r_termCnt == c_LAST_TERM));

   // The first term of a packet starts from zero rather than the old sum.
   assign w_base   = (r_cnt == '0) ? '0 : r_acc;
   assign w_addend = ACC_W'(r_prodQ);

`ifdef MAC_SAT_EN
   logic [ACC_W:0] w_sum;
   logic           r_ovf;

   assign w_sum  = {1'b0, w_base} + {1'b0, w_addend};
   assign w_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

   // Sticky for the packet; cleared together with the sum on handshake.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ovf <= 1'b0;
      end else if ((r_state == DONE) && out_ready) begin
         r_ovf <= 1'b0;
      end else if (r_prodV && w_sum[ACC_W]) begin
         r_ovf <= 1'b1;
      end
   end

   assign out_ovf = r_ovf;
`else
   assign w_next  = w_base + w_addend;
   assign out_ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ACC;
         r_inReady  <= 1'b0;
         r_outValid <= 1'b0;
         r_prodQ    <= '0;
         r_prodV    <= 1'b0;
         r_prodLast <= 1'b0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_termCnt  <= '0;
      end else begin
         r_prodV    <= w_accept;
         r_prodLast <= w_terminal;
         if (w_accept) begin
            r_prodQ   <= w_prod;
            r_termCnt <= w_terminal ? '0 : r_termCnt + 1'b1;
         end
         if (r_prodV) begin
            r_acc <= w_next;
            r_cnt <= r_cnt + 1'b1;
         end

         case (r_state)
            ACC: begin
               r_inReady <= 1'b1;
               if (w_terminal) begin
                  r_inReady <= 1'b0;
                  r_state   <= FLUSH;
               end
            end
            FLUSH: begin
               // The terminal product is being accumulated this cycle; the
               // registered terminal flag raises the result valid with it.
               r_outValid <= r_prodLast;
               r_state    <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_state    <= ACC;
               end
            end
            default: begin
               r_state <= ACC;
            end
         endcase
      end
   end

   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign out_sum   = r_acc;
   assign out_count = r_cnt;

endmodule : wal_mac_dot
`default_nettype wire

// File: tb/tb_wal_mac_dot.sv
`default_nettype none
//==============================================================================
// Module      : tb_wal_mac_dot
// Description : Self-checking bench for wal_mac_dot. Two instances share clock
//               and reset: A (N_TERMS=4, ACC_W=20) and B (N_TERMS=8, ACC_W=16);
//               `sel` steers stimulus and observation to one of them.
//               Directed scenarios are followed by random packets checked
//               against an arithmetic reference model.
//               Honours MAC_SAT_EN for the expected saturation behaviour.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_wal_mac_dot;

   localparam int NA = 4;
   localparam int WA = 20;
   localparam int NB = 8;
   localparam int WB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       vld;
   logic       lst;
   logic       ordy;
   logic [7:0] a;
   logic [7:0] b;
   int         sel;

   logic          vA, vB, orA, orB;
   logic          rdA, rdB, ovA, ovB, ofA, ofB;
   logic [WA-1:0] sumA;
   logic [WB-1:0] sumB;
   logic [7:0]    cntA, cntB;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign vA  = vld  && (sel == 0);
   assign vB  = vld  && (sel == 1);
   assign orA = ordy && (sel == 0);
   assign orB = ordy && (sel == 1);

   wal_mac_dot #(.N_TERMS(NA), .ACC_W(WA)) dutA (
      .clk(clk), .rst(rst), .in_valid(vA), .in_ready(rdA), .in_a(a), .in_b(b),
      .in_last(lst), .out_valid(ovA), .out_ready(orA), .out_sum(sumA),
      .out_count(cntA), .out_ovf(ofA)
   );

   wal_mac_dot #(.N_TERMS(NB), .ACC_W(WB)) dutB (
      .clk(clk), .rst(rst), .in_valid(vB), .in_ready(rdB), .in_a(a), .in_b(b),
      .in_last(lst), .out_valid(ovB), .out_ready(orB), .out_sum(sumB),
      .out_count(cntB), .out_ovf(ofB)
   );

   function automatic logic        f_rdy(); return (sel == 0) ? rdA : rdB; endfunction
   function automatic logic        f_ov();  return (sel == 0) ? ovA : ovB; endfunction
   function automatic logic        f_ovf(); return (sel == 0) ? ofA : ofB; endfunction
   function automatic logic [7:0]  f_cnt(); return (sel == 0) ? cntA : cntB; endfunction
   function automatic logic [31:0] f_sum(); return (sel == 0) ? 32'(sumA) : 32'(sumB); endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer sum of the packet's products, then either
   // clamped to the accumulator range (saturating build) or taken modulo it.
   function automatic void model(input int s, input int prods[$],
                                 output logic [31:0] es, output logic eo);
      longint tot = 0;
      longint lim = 64'd1 << ((s == 0) ? WA : WB);
      foreach (prods[i]) tot += prods[i];
`ifdef MAC_SAT_EN
      if (tot >= lim) begin es = 32'(lim - 1); eo = 1'b1; end
      else            begin es = 32'(tot);     eo = 1'b0; end
`else
      es = 32'(tot % lim);
      eo = 1'b0;
`endif
   endfunction

   // Called and returns just after a falling edge; the beat is accepted on
   // the rising edge in between.
   task automatic beat(input logic [7:0] aa, input logic [7:0] bb, input logic ll);
      int wt = 0;
      a = aa; b = bb; lst = ll; vld = 1'b1;
      while (!f_rdy() && wt < 20) begin @(negedge clk); wt++; end
      chk("in_ready_beat", f_rdy(), 1'b1);
      @(negedge clk);
      vld = 1'b0; lst = 1'b0;
   endtask

   task automatic get_result(input string tag, input logic [31:0] es, input logic [7:0] ec,
                             input logic eo, input int hold);
      int wt = 0;
      while (!f_ov() && wt < 10) begin @(negedge clk); wt++; end
      chk({tag, "_valid"}, f_ov(), 1'b1);
      chk({tag, "_sum"},   f_sum(), es);
      chk({tag, "_count"}, f_cnt(), ec);
      chk({tag, "_ovf"},   f_ovf(), eo);
      repeat (hold) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, f_ov(), 1'b1);
         chk({tag, "_hold_sum"},   f_sum(), es);
         chk({tag, "_hold_count"}, f_cnt(), ec);
         chk({tag, "_hold_rdy"},   f_rdy(), 1'b0);
      end
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
      chk({tag, "_post_valid"}, f_ov(), 1'b0);
      chk({tag, "_post_rdy"},   f_rdy(), 1'b1);
      chk({tag, "_post_count"}, f_cnt(), 8'd0);
      chk({tag, "_post_ovf"},   f_ovf(), 1'b0);
   endtask

   initial begin
      logic [31:0] es;
      logic        eo;
      int          prods[$];

      rst = 1'b0; vld = 1'b0; lst = 1'b0; ordy = 1'b0; a = '0; b = '0; sel = 0;
      repeat (3) @(negedge clk);

      // reset state of both instances
      for (int s = 0; s < 2; s++) begin
         sel = s;
         chk("rst_rdy",   f_rdy(), 1'b0);
         chk("rst_valid", f_ov(),  1'b0);
         chk("rst_sum",   f_sum(), 32'd0);
         chk("rst_count", f_cnt(), 8'd0);
         chk("rst_ovf",   f_ovf(), 1'b0);
      end
      rst = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         chk("rel_rdy", f_rdy(), 1'b1);
      end

      // full packet by term count, latency, and a 5-cycle stall in DONE
      sel = 0;
      beat(8'd1, 8'd1, 1'b0);
      beat(8'd2, 8'd3, 1'b0);
      beat(8'd255, 8'd255, 1'b0);
      beat(8'd16, 8'd16, 1'b0);
      chk("lat_flush_valid", f_ov(),  1'b0);
      chk("lat_flush_rdy",   f_rdy(), 1'b0);
      @(negedge clk);
      chk("lat_done_valid", f_ov(), 1'b1);
      get_result("t1", 32'd65288, 8'd4, 1'b0, 5);

      // early termination and no carry-over into the next packet
      beat(8'd10, 8'd10, 1'b0);
      beat(8'd20, 8'd20, 1'b1);
      get_result("t2a", 32'd500, 8'd2, 1'b0, 0);
      beat(8'd3, 8'd3, 1'b1);
      get_result("t2b", 32'd9, 8'd1, 1'b0, 0);

      // 16-bit accumulator overflow
      sel = 1;
      for (int i = 0; i < 4; i++) beat(8'd255, 8'd255, (i == 3));
`ifdef MAC_SAT_EN
      get_result("sat", 32'h0000FFFF, 8'd4, 1'b1, 0);
`else
      get_result("sat", 32'h0000F804, 8'd4, 1'b0, 0);
`endif

      // reset in the middle of a packet discards the partial sum
      sel = 0;
      beat(8'd5, 8'd5, 1'b0);
      beat(8'd5, 8'd5, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", f_ov(),  1'b0);
      chk("mid_rst_rdy",   f_rdy(), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rel_rdy",   f_rdy(), 1'b1);
      chk("mid_rel_sum",   f_sum(), 32'd0);
      chk("mid_rel_count", f_cnt(), 8'd0);
      for (int i = 0; i < 4; i++) beat(8'd3, 8'd3, 1'b0);
      get_result("t5", 32'd36, 8'd4, 1'b0, 0);

      // in_valid every other cycle; idle cycles leave the running sum alone
      sel = 1;
      for (int i = 0; i < 8; i++) begin
         beat(8'd2, 8'd2, (i == 7));
         @(negedge clk);
         chk("gap_count", f_cnt(), 8'(i + 1));
         chk("gap_sum",   f_sum(), 32'(4 * (i + 1)));
      end
      get_result("t6", 32'd32, 8'd8, 1'b0, 0);

      // random packets against the reference model
      for (int p = 0; p < 40; p++) begin
         int nmax, len;
         logic useLast;
         logic [7:0] ra, rb;
         sel     = $urandom_range(0, 1);
         nmax    = (sel == 0) ? NA : NB;
         len     = $urandom_range(1, nmax);
         useLast = (len < nmax) ? 1'b1 : 1'($urandom_range(0, 1));
         prods.delete();
         for (int i = 0; i < len; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            prods.push_back(int'(ra) * int'(rb));
            beat(ra, rb, useLast && (i == len - 1));
            if (i < len - 1 && $urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 2)) @(negedge clk);
         end
         model(sel, prods, es, eo);
         get_result("rnd", es, 8'(len), eo, $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule : tb_wal_mac_dot
`default_nettype wire
